// File: rtl/alu_exception_stage_if.sv
// Bundle between the ALU, the exception stage, the memory stage and the exception handler.
// CNT_W must match the CNT_W of the stage this bundle is connected to.
interface alu_exception_stage_if #(
  parameter int CNT_W = 8
);
  logic              in_valid;
  logic [3:0]        alu_control;
  logic [31:0]       alu_result;
  logic [7:0]        alu_status;
  logic [31:0]       pc;
  logic              exc_ack;

  logic              out_valid;
  logic [31:0]       out_result;
  logic              out_zero;
  logic              out_neg;
  logic              exc_req;
  logic [2:0]        exc_cause;
  logic [31:0]       epc;
  logic [31:0]       bad_addr;
  logic              flush;
  logic              stall;
  logic [CNT_W-1:0]  exc_count;

  modport master (
    output in_valid, alu_control, alu_result, alu_status, pc, exc_ack,
    input  out_valid, out_result, out_zero, out_neg, exc_req, exc_cause,
           epc, bad_addr, flush, stall, exc_count
  );

  modport slave (
    input  in_valid, alu_control, alu_result, alu_status, pc, exc_ack,
    output out_valid, out_result, out_zero, out_neg, exc_req, exc_cause,
           epc, bad_addr, flush, stall, exc_count
  );
endinterface

// File: rtl/alu_exception_stage.sv
// Registered stage after the ALU: forwards results to memory and traps ALU exceptions,
// holding the pipeline until the handler acknowledges.
module alu_exception_stage #(
  parameter int         CNT_W    = 8,
  parameter logic [2:0] EXC_MASK = 3'b111
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_exception_stage_if.slave bus
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] TRAP     = 2'd1;
  localparam logic [1:0] WAIT_ACK = 2'd2;

  logic [1:0] state;
  logic       div0;
  logic       movf;
  logic       mis;
  logic [2:0] cause;
  logic       exc_hit;
  logic       unused_status;

  assign unused_status = ^{bus.alu_status[5], bus.alu_status[1:0]};

  // A masked term simply drops out, so a lower-priority cause can still win.
  always_comb begin
    div0 = EXC_MASK[0] & (bus.alu_control == 4'd4) & bus.alu_status[2];
    movf = EXC_MASK[1] & (bus.alu_control == 4'd5) & bus.alu_status[6];
    mis  = EXC_MASK[2] & (((bus.alu_control == 4'd12) & ~bus.alu_status[3]) |
                          ((bus.alu_control == 4'd13) &  bus.alu_status[3]));
    cause = 3'b000;
    if (div0)      cause = 3'b001;
    else if (movf) cause = 3'b010;
    else if (mis)  cause = 3'b100;
    exc_hit = |cause;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      bus.out_valid  <= 1'b0;
      bus.out_result <= 32'd0;
      bus.out_zero   <= 1'b0;
      bus.out_neg    <= 1'b0;
      bus.exc_req    <= 1'b0;
      bus.exc_cause  <= 3'b000;
      bus.epc        <= 32'd0;
      bus.bad_addr   <= 32'd0;
      bus.flush      <= 1'b0;
      bus.stall      <= 1'b0;
      bus.exc_count  <= '0;
    end else begin
      bus.flush <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid && exc_hit) begin
            state         <= TRAP;
            bus.out_valid <= 1'b0;
            bus.exc_req   <= 1'b1;
            bus.flush     <= 1'b1;
            bus.stall     <= 1'b1;
            bus.epc       <= bus.pc;
            bus.exc_cause <= cause;
            bus.bad_addr  <= cause[2] ? bus.alu_result : 32'd0;
            if (bus.exc_count != {CNT_W{1'b1}})
              bus.exc_count <= bus.exc_count + CNT_W'(1);
          end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
              bus.out_result <= bus.alu_result;
              bus.out_zero   <= bus.alu_status[7];
              bus.out_neg    <= bus.alu_status[4];
            end
          end
        end
        // TRAP and WAIT_ACK differ only in the flush pulse, which is cleared above.
        TRAP, WAIT_ACK: begin
          bus.out_valid <= 1'b0;
          if (bus.exc_ack) begin
            state       <= IDLE;
            bus.exc_req <= 1'b0;
            bus.stall   <= 1'b0;
          end else begin
            state <= WAIT_ACK;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
